xor_parity_frame_checker: RTL



---
 rtl/xor_parity_frame_checker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/xor_parity_frame_checker.sv
// Per-frame parity checker behind the 16-input XOR parity tree.
// Accumulates parity, mismatch count, length and over-length per frame,
// and presents one registered result per frame on a valid/ready port.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     word handshake; in_par, in_exp, in_last payload
//   res_valid/res_ready   result handshake; res_frame_par, res_err_cnt,
//                         res_words, res_overlen, res_bad payload
//   clr_stats             sync clear of lifetime counters
//   tot_frames, tot_bad   saturating lifetime counters
module xor_parity_frame_checker #(
    parameter int CNT_W     = 8,
    parameter int LEN_W     = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_par,
    input  logic             in_exp,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_frame_par,
    output logic [CNT_W-1:0] res_err_cnt,
    output logic [LEN_W-1:0] res_words,
    output logic             res_overlen,
    output logic             res_bad,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] tot_frames,
    output logic [CNT_W-1:0] tot_bad
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_LIM = LEN_W'(MAX_WORDS);

    state_t           state_q, state_d;

    logic             acc_par_q;
    logic [CNT_W-1:0] acc_err_q;
    logic [LEN_W-1:0] acc_words_q;
    logic             acc_ovl_q;

    logic             res_par_q;
    logic [CNT_W-1:0] res_err_q;
    logic [LEN_W-1:0] res_words_q;
    logic             res_ovl_q;
    logic             res_bad_q;

    logic [CNT_W-1:0] tot_frames_q;
    logic [CNT_W-1:0] tot_bad_q;

    logic             accept;
    logic             fin;
    logic             par_d;
    logic [CNT_W-1:0] err_d;
    logic [LEN_W-1:0] words_d;
    logic             ovl_d;
    logic             bad_d;

    // Accumulator values including the word offered this cycle.
    always_comb begin
        in_ready = (state_q == ACCUM) || res_ready;
        accept   = in_valid && in_ready;
        fin      = accept && in_last;
        par_d    = acc_par_q ^ in_par;
        err_d    = acc_err_q;
        if ((in_par != in_exp) && (acc_err_q != CNT_MAX)) begin
            err_d = acc_err_q + CNT_W'(1);
        end
        words_d = acc_words_q;
        if (acc_words_q != LEN_MAX) begin
            words_d = acc_words_q + LEN_W'(1);
        end
        // Word count equal to the limit before this word means this
        // word is one past the limit.
        ovl_d = acc_ovl_q || (acc_words_q == LEN_LIM);
        bad_d = (err_d != '0) || ovl_d;
    end

    // A last word accepted in HOLD (only possible with res_ready)
    // replaces the consumed result without a bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (fin) state_d = HOLD;
            HOLD:  if (res_ready && !fin) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            acc_par_q    <= 1'b0;
            acc_err_q    <= '0;
            acc_words_q  <= '0;
            acc_ovl_q    <= 1'b0;
            res_par_q    <= 1'b0;
            res_err_q    <= '0;
            res_words_q  <= '0;
            res_ovl_q    <= 1'b0;
            res_bad_q    <= 1'b0;
            tot_frames_q <= '0;
            tot_bad_q    <= '0;
        end else begin
            state_q <= state_d;
            if (fin) begin
                res_par_q   <= par_d;
                res_err_q   <= err_d;
                res_words_q <= words_d;
                res_ovl_q   <= ovl_d;
                res_bad_q   <= bad_d;
                acc_par_q   <= 1'b0;
                acc_err_q   <= '0;
                acc_words_q <= '0;
                acc_ovl_q   <= 1'b0;
            end else if (accept) begin
                acc_par_q   <= par_d;
                acc_err_q   <= err_d;
                acc_words_q <= words_d;
                acc_ovl_q   <= ovl_d;
            end
            // Clear wins over a frame completing in the same cycle.
            if (clr_stats) begin
                tot_frames_q <= '0;
                tot_bad_q    <= '0;
            end else if (fin) begin
                if (tot_frames_q != CNT_MAX) begin
                    tot_frames_q <= tot_frames_q + CNT_W'(1);
                end
                if (bad_d && (tot_bad_q != CNT_MAX)) begin
                    tot_bad_q <= tot_bad_q + CNT_W'(1);
                end
            end
        end
    end

    assign res_valid     = (state_q == HOLD);
    assign res_frame_par = res_par_q;
    assign res_err_cnt   = res_err_q;
    assign res_words     = res_words_q;
    assign res_overlen   = res_ovl_q;
    assign res_bad       = res_bad_q;
    assign tot_frames    = tot_frames_q;
    assign tot_bad       = tot_bad_q;

endmodule
